// File: rtl/wb_pkg.sv
`default_nettype none
// ============================================================================
// Module   : wb_pkg
// Purpose  : Shared constants for the accumulator write-back stage.
//            Accumulator control word bit positions, bubble encoding, and
//            default widths.
// Revision : 1.0 - initial release
// ============================================================================
package wb_pkg;

  // Accumulator control word bit positions
  localparam int CTRL_WR_A = 0;  // write accumulator A
  localparam int CTRL_WR_B = 1;  // write accumulator B
  localparam int CTRL_CLR  = 2;  // write zero instead of the data

  localparam logic [2:0] CTRL_BUBBLE = 3'b000;

  localparam int DEFAULT_DATA_W = 8;
  localparam int DEFAULT_CNT_W  = 16;

endpackage : wb_pkg
`default_nettype wire

// File: rtl/acum_reg.sv
`default_nettype none
// ============================================================================
// Module   : acum_reg
// Purpose  : One architectural accumulator with write enable, async reset,
//            and registered zero / negative flags.
// Ports    : Clock, Reset  - clock, async active-high reset
//            iWrEn         - commit a write this edge
//            iWrData       - value to commit
//            oValue        - accumulator value (bypassed when enabled)
//            oZero, oNeg   - flags of oValue
// Config   : WB_ACUM_FWD_EN - when defined, outputs show the pending write
//            value combinationally while iWrEn is high.
// Revision : 1.0 - initial release
// ============================================================================
module acum_reg #(
  parameter int DATA_W = 8
) (
  input  logic              Clock,
  input  logic              Reset,
  input  logic              iWrEn,
  input  logic [DATA_W-1:0] iWrData,
  output logic [DATA_W-1:0] oValue,
  output logic              oZero,
  output logic              oNeg
);

  logic [DATA_W-1:0] value_q, value_d;
  logic              zero_q, zero_d;
  logic              neg_q, neg_d;

  // Flags are computed from the value being loaded so they are always
  // registered together with it and can never go stale.
  always_comb begin
    value_d = value_q;
    zero_d  = zero_q;
    neg_d   = neg_q;
    if (iWrEn) begin
      value_d = iWrData;
      zero_d  = (iWrData == '0);
      neg_d   = iWrData[DATA_W-1];
    end
  end

  always_ff @(posedge Clock or posedge Reset) begin
    if (Reset) begin
      value_q <= '0;
      zero_q  <= 1'b1;
      neg_q   <= 1'b0;
    end else begin
      value_q <= value_d;
      zero_q  <= zero_d;
      neg_q   <= neg_d;
    end
  end

`ifdef WB_ACUM_FWD_EN
  // Same-cycle bypass: show the write that will land on the next edge.
  assign oValue = iWrEn ? iWrData : value_q;
  assign oZero  = iWrEn ? (iWrData == '0) : zero_q;
  assign oNeg   = iWrEn ? iWrData[DATA_W-1] : neg_q;
`else
  assign oValue = value_q;
  assign oZero  = zero_q;
  assign oNeg   = neg_q;
`endif

endmodule : acum_reg
`default_nettype wire

// File: rtl/wb_acum.sv
`default_nettype none
// ============================================================================
// Module   : wb_acum
// Purpose  : Write-back stage of the accumulator pipeline. Holds the MEM/WB
//            pipeline register, accumulators A and B with flags, and a
//            retired-write counter.
// Ports    : Clock, Reset        - clock, async active-high reset
//            iDataToWB           - MEM stage result
//            iControlAcum_MEM    - {CLR, WR_B, WR_A} from MEM
//            iStall              - hold register, no commit
//            oAcumA/oAcumB       - accumulator values to EX
//            oZeroA/B, oNegA/B   - accumulator flags
//            oWbValid            - MEM/WB register holds a non-bubble entry
//            oWriteCount         - committed writes (wrapping)
// Config   : WB_ACUM_FWD_EN - combinational bypass of the pending write onto
//            the accumulator outputs (latency 1 edge instead of 2).
// Revision : 1.0 - initial release
// ============================================================================
module wb_acum
  import wb_pkg::*;
#(
  parameter int DATA_W = DEFAULT_DATA_W,
  parameter int CNT_W  = DEFAULT_CNT_W
) (
  input  logic              Clock,
  input  logic              Reset,
  input  logic [DATA_W-1:0] iDataToWB,
  input  logic [2:0]        iControlAcum_MEM,
  input  logic              iStall,
  output logic [DATA_W-1:0] oAcumA,
  output logic [DATA_W-1:0] oAcumB,
  output logic              oZeroA,
  output logic              oZeroB,
  output logic              oNegA,
  output logic              oNegB,
  output logic              oWbValid,
  output logic [CNT_W-1:0]  oWriteCount
);

  logic [2:0]        ctrl_q, ctrl_d;
  logic [DATA_W-1:0] data_q, data_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;

  logic              w_wr_a;
  logic              w_wr_b;
  logic [DATA_W-1:0] w_wr_val;

  // The entry in the MEM/WB register commits on every non-stalled edge.
  assign w_wr_a   = ~iStall & ctrl_q[CTRL_WR_A];
  assign w_wr_b   = ~iStall & ctrl_q[CTRL_WR_B];
  assign w_wr_val = ctrl_q[CTRL_CLR] ? '0 : data_q;

  always_comb begin
    ctrl_d = ctrl_q;
    data_d = data_q;
    cnt_d  = cnt_q;
    if (!iStall) begin
      ctrl_d = iControlAcum_MEM;
      data_d = iDataToWB;
      // A dual write retires as a single entry.
      if (w_wr_a | w_wr_b) begin
        cnt_d = cnt_q + CNT_W'(1);
      end
    end
  end

  always_ff @(posedge Clock or posedge Reset) begin
    if (Reset) begin
      ctrl_q <= CTRL_BUBBLE;
      data_q <= '0;
      cnt_q  <= '0;
    end else begin
      ctrl_q <= ctrl_d;
      data_q <= data_d;
      cnt_q  <= cnt_d;
    end
  end

  acum_reg #(.DATA_W(DATA_W)) u_acum_a (
    .Clock   (Clock),
    .Reset   (Reset),
    .iWrEn   (w_wr_a),
    .iWrData (w_wr_val),
    .oValue  (oAcumA),
    .oZero   (oZeroA),
    .oNeg    (oNegA)
  );

  acum_reg #(.DATA_W(DATA_W)) u_acum_b (
    .Clock   (Clock),
    .Reset   (Reset),
    .iWrEn   (w_wr_b),
    .iWrData (w_wr_val),
    .oValue  (oAcumB),
    .oZero   (oZeroB),
    .oNeg    (oNegB)
  );

  // 3'b100 selects no target, so it is not a valid entry.
  assign oWbValid    = |ctrl_q[CTRL_WR_B:CTRL_WR_A];
  assign oWriteCount = cnt_q;

endmodule : wb_acum
`default_nettype wire
